// File: rtl/vsharp_fsm_pkg.sv
// Shared types and defaults for generated FSMs and their call/return sequencer.
package vsharp_fsm_pkg;

    localparam int unsigned STATE_W_DEFAULT = 8;
    localparam int unsigned DATA_W_DEFAULT  = 32;

    localparam logic [STATE_W_DEFAULT-1:0] STATE_INITIAL = 8'd0;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        ERROR = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/lifo_stack.sv
// Small register-based LIFO. The top entry is presented combinationally on dout.
module lifo_stack
    import vsharp_fsm_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CntW-1:0]  count
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CntW-1:0]  count_q, count_d;
    logic [CntW-1:0]  top_cnt;
    logic [IdxW-1:0]  top_idx;
    logic [IdxW-1:0]  wr_idx;

    assign full  = (count_q == CntW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    always_comb begin
        top_cnt = count_q - CntW'(1);
        top_idx = IdxW'(top_cnt);
        wr_idx  = IdxW'(count_q);
        dout    = empty ? '0 : mem_q[top_idx];
    end

    // Push and pop are mutually exclusive at the caller; guards keep the count from wrapping.
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (push && !full) begin
            mem_d[wr_idx] = din;
            count_d       = count_q + CntW'(1);
        end else if (pop && !empty) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/fsm_call_ctrl.sv
// Call/return sequencer: pushes resume states on call, pops them on return and
// steers the caller's state register through a one-cycle next_state pulse.
module fsm_call_ctrl
    import vsharp_fsm_pkg::*;
#(
    parameter int unsigned STATE_W = STATE_W_DEFAULT,
    parameter int unsigned DATA_W  = DATA_W_DEFAULT,
    parameter int unsigned DEPTH   = 4,
    localparam int unsigned CntW   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               call_valid,
    input  logic [STATE_W-1:0] call_target,
    input  logic [STATE_W-1:0] call_resume,
    input  logic               ret_valid,
    input  logic [DATA_W-1:0]  ret_value,
    output logic               next_state_valid,
    output logic [STATE_W-1:0] next_state,
    output logic [DATA_W-1:0]  ret_data,
    output logic               ret_data_valid,
    output logic [CntW-1:0]    depth,
    output logic               overflow,
    output logic               underflow,
    output logic               protocol_err
);

    ctrl_state_e        state_q, state_d;
    logic               nsv_q, nsv_d;
    logic [STATE_W-1:0] ns_q, ns_d;
    logic [DATA_W-1:0]  rd_q, rd_d;
    logic               rdv_q, rdv_d;
    logic               ovf_q, ovf_d;
    logic               udf_q, udf_d;
    logic               perr_q, perr_d;

    logic               push, pop;
    logic [STATE_W-1:0] top;
    logic               full, empty;

    lifo_stack #(
        .WIDTH (STATE_W),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (call_resume),
        .dout  (top),
        .full  (full),
        .empty (empty),
        .count (depth)
    );

    always_comb begin
        state_d = state_q;
        nsv_d   = 1'b0;
        rdv_d   = 1'b0;
        ns_d    = ns_q;
        rd_d    = rd_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        perr_d  = perr_q;
        push    = 1'b0;
        pop     = 1'b0;
        // ERROR is absorbing: everything holds until reset.
        if (state_q == RUN) begin
            if (call_valid && ret_valid) begin
                perr_d  = 1'b1;
                state_d = ERROR;
            end else if (call_valid) begin
                if (full) begin
                    ovf_d   = 1'b1;
                    state_d = ERROR;
                end else begin
                    push  = 1'b1;
                    ns_d  = call_target;
                    nsv_d = 1'b1;
                end
            end else if (ret_valid) begin
                if (empty) begin
                    udf_d   = 1'b1;
                    state_d = ERROR;
                end else begin
                    pop   = 1'b1;
                    ns_d  = top;
                    rd_d  = ret_value;
                    nsv_d = 1'b1;
                    rdv_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            nsv_q   <= 1'b0;
            ns_q    <= '0;
            rd_q    <= '0;
            rdv_q   <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            nsv_q   <= nsv_d;
            ns_q    <= ns_d;
            rd_q    <= rd_d;
            rdv_q   <= rdv_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            perr_q  <= perr_d;
        end
    end

    assign next_state_valid = nsv_q;
    assign next_state       = ns_q;
    assign ret_data         = rd_q;
    assign ret_data_valid   = rdv_q;
    assign overflow         = ovf_q;
    assign underflow        = udf_q;
    assign protocol_err     = perr_q;

endmodule

// File: tb/tb_fsm_call_ctrl.sv
// Directed bench for fsm_call_ctrl with hand-computed expectations.
module tb_fsm_call_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        call_valid;
    logic [7:0]  call_target;
    logic [7:0]  call_resume;
    logic        ret_valid;
    logic [31:0] ret_value;
    logic        next_state_valid;
    logic [7:0]  next_state;
    logic [31:0] ret_data;
    logic        ret_data_valid;
    logic [2:0]  depth;
    logic        overflow;
    logic        underflow;
    logic        protocol_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fsm_call_ctrl #(
        .STATE_W (8),
        .DATA_W  (32),
        .DEPTH   (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .call_valid       (call_valid),
        .call_target      (call_target),
        .call_resume      (call_resume),
        .ret_valid        (ret_valid),
        .ret_value        (ret_value),
        .next_state_valid (next_state_valid),
        .next_state       (next_state),
        .ret_data         (ret_data),
        .ret_data_valid   (ret_data_valid),
        .depth            (depth),
        .overflow         (overflow),
        .underflow        (underflow),
        .protocol_err     (protocol_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it in, then settle just past the edge.
    task automatic step(input logic rst, input logic cv, input logic [7:0] ct,
                        input logic [7:0] cr, input logic rv, input logic [31:0] val);
        reset       = rst;
        call_valid  = cv;
        call_target = ct;
        call_resume = cr;
        ret_valid   = rv;
        ret_value   = val;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 32'h0);
    endtask

    task automatic do_call(input logic [7:0] t, input logic [7:0] r);
        step(1'b0, 1'b1, t, r, 1'b0, 32'h0);
    endtask

    task automatic do_ret(input logic [31:0] v);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, v);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 32'h0);
    endtask

    task automatic check_flags(input string tag, input logic o, input logic u, input logic p);
        check({tag, ".overflow"}, 64'(overflow), 64'(o));
        check({tag, ".underflow"}, 64'(underflow), 64'(u));
        check({tag, ".protocol_err"}, 64'(protocol_err), 64'(p));
    endtask

    initial begin
        do_reset();
        do_reset();
        idle();
        check("rst.nsv", 64'(next_state_valid), 64'd0);
        check("rst.ns", 64'(next_state), 64'd0);
        check("rst.rd", 64'(ret_data), 64'd0);
        check("rst.rdv", 64'(ret_data_valid), 64'd0);
        check("rst.depth", 64'(depth), 64'd0);
        check_flags("rst", 1'b0, 1'b0, 1'b0);

        // Single call/return
        do_call(8'h05, 8'h02);
        check("call1.nsv", 64'(next_state_valid), 64'd1);
        check("call1.ns", 64'(next_state), 64'h05);
        check("call1.rdv", 64'(ret_data_valid), 64'd0);
        check("call1.depth", 64'(depth), 64'd1);
        idle();
        check("call1.pulse_end", 64'(next_state_valid), 64'd0);
        check("call1.ns_hold", 64'(next_state), 64'h05);
        do_ret(32'h3);
        check("ret1.nsv", 64'(next_state_valid), 64'd1);
        check("ret1.ns", 64'(next_state), 64'h02);
        check("ret1.rd", 64'(ret_data), 64'h3);
        check("ret1.rdv", 64'(ret_data_valid), 64'd1);
        check("ret1.depth", 64'(depth), 64'd0);
        idle();
        check("ret1.rdv_end", 64'(ret_data_valid), 64'd0);
        check("ret1.rd_hold", 64'(ret_data), 64'h3);

        // Nested calls, back to back
        do_call(8'h20, 8'h10);
        do_call(8'h21, 8'h11);
        check("nest.ns2", 64'(next_state), 64'h21);
        do_call(8'h22, 8'h12);
        check("nest.ns3", 64'(next_state), 64'h22);
        check("nest.depth3", 64'(depth), 64'd3);
        do_ret(32'hA);
        check("nest.pop1", 64'(next_state), 64'h12);
        check("nest.rd1", 64'(ret_data), 64'hA);
        do_ret(32'hB);
        check("nest.pop2", 64'(next_state), 64'h11);
        check("nest.nsv2", 64'(next_state_valid), 64'd1);
        do_ret(32'hC);
        check("nest.pop3", 64'(next_state), 64'h10);
        check("nest.rd3", 64'(ret_data), 64'hC);
        check("nest.depth0", 64'(depth), 64'd0);
        check_flags("nest", 1'b0, 1'b0, 1'b0);

        // Overflow
        for (int i = 0; i < 4; i++) begin
            do_call(8'h30 + 8'(i), 8'h40 + 8'(i));
        end
        check("ovf.depth4", 64'(depth), 64'd4);
        do_call(8'h3F, 8'h4F);
        check("ovf.nsv", 64'(next_state_valid), 64'd0);
        check("ovf.depth", 64'(depth), 64'd4);
        check("ovf.ns_hold", 64'(next_state), 64'h33);
        check_flags("ovf", 1'b1, 1'b0, 1'b0);
        do_ret(32'h55);
        check("ovf.ret_nsv", 64'(next_state_valid), 64'd0);
        check("ovf.ret_rdv", 64'(ret_data_valid), 64'd0);
        check("ovf.ret_depth", 64'(depth), 64'd4);

        // Underflow
        do_reset();
        do_ret(32'h66);
        check("udf.nsv", 64'(next_state_valid), 64'd0);
        check("udf.depth", 64'(depth), 64'd0);
        check_flags("udf", 1'b0, 1'b1, 1'b0);
        idle();
        check("udf.sticky", 64'(underflow), 64'd1);

        // Simultaneous call and return
        do_reset();
        do_call(8'h50, 8'h51);
        step(1'b0, 1'b1, 8'h52, 8'h53, 1'b1, 32'h77);
        check("perr.depth", 64'(depth), 64'd1);
        check("perr.nsv", 64'(next_state_valid), 64'd0);
        check("perr.rdv", 64'(ret_data_valid), 64'd0);
        check_flags("perr", 1'b0, 1'b0, 1'b1);

        // Reset mid-operation with a concurrent call request
        do_reset();
        do_call(8'h60, 8'h61);
        do_call(8'h62, 8'h63);
        check("rmid.depth2", 64'(depth), 64'd2);
        step(1'b1, 1'b1, 8'h64, 8'h65, 1'b0, 32'h0);
        check("rmid.depth", 64'(depth), 64'd0);
        check("rmid.nsv", 64'(next_state_valid), 64'd0);
        check("rmid.ns", 64'(next_state), 64'd0);
        check_flags("rmid", 1'b0, 1'b0, 1'b0);
        do_call(8'h70, 8'h71);
        check("rmid.call_ns", 64'(next_state), 64'h70);
        check("rmid.call_depth", 64'(depth), 64'd1);
        do_ret(32'hDEAD);
        check("rmid.ret_ns", 64'(next_state), 64'h71);
        check("rmid.ret_rd", 64'(ret_data), 64'hDEAD);
        check("rmid.ret_rdv", 64'(ret_data_valid), 64'd1);
        check("rmid.ret_depth", 64'(depth), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
